// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
// uart_dbg_pkg - command/reply codes and FSM encodings for the UART debug bridge. Rev 1.0
// ============================================================================
package uart_dbg_pkg;

  localparam logic [7:0]  CMD_WR      = 8'h57;
  localparam logic [7:0]  CMD_RD      = 8'h52;
  localparam logic [7:0]  CMD_HALT    = 8'h48;
  localparam logic [7:0]  RSP_OK      = 8'h4B;
  localparam logic [7:0]  RSP_ERR     = 8'h45;
  localparam logic [15:0] DEF_CLK_DIV = 16'h1B8;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ADDR = 5'b00010,
    S_DATA = 5'b00100,
    S_BUS  = 5'b01000,
    S_RESP = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx - 8N1 byte receiver: 2-FF sync, start glitch reject, mid-bit sampling. Rev 1.0
// ============================================================================
module uart_byte_rx
  import uart_dbg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic       start_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  logic [1:0]  sync_q;
  logic        prev_q;
  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      start_o      <= 1'b0;
      byte_valid_o <= 1'b0;
      byte_data_o  <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      prev_q       <= rx_s;
      start_o      <= 1'b0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !rx_s) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is gone by mid-period is treated as line noise.
          if (cnt_q == (CLK_DIV >> 1)) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= RX_IDLE;
            end else begin
              state_q <= RX_DATA;
              bit_q   <= '0;
              start_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CLK_DIV) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CLK_DIV) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_s) begin
              byte_valid_o <= 1'b1;
              byte_data_o  <= shift_q;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_dbg_bridge.sv
`default_nettype none
// ============================================================================
// uart_dbg_bridge - UART host to 32-bit bus debug master; option UART_DBG_HALT_EN adds halt_o. Rev 1.0
// ============================================================================
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV     = DEF_CLK_DIV,
  parameter logic [31:0] TIMEOUT_CYC = 32'd5000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        ack_i,
`ifdef UART_DBG_HALT_EN
  output logic        halt_o,
`endif
  output logic        busy_o
);

  logic        rx_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ferr;

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [2:0]  idx_q;
  logic [31:0] tout_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        busy_q;
  logic [31:0] rsp_q;
  logic [2:0]  rsp_left_q;
  logic [9:0]  tx_sh_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_act_q;
  logic        cmd_ok;
  logic        tx_load;
`ifdef UART_DBG_HALT_EN
  logic        halt_q;
  assign halt_o = halt_q;
`endif

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk          (clk),
    .rstn         (rstn),
    .rx_i         (rx_pin),
    .start_o      (rx_start),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_data),
    .frame_err_o  (rx_ferr)
  );

  always_comb begin
    cmd_ok = (rx_data == CMD_WR) || (rx_data == CMD_RD);
`ifdef UART_DBG_HALT_EN
    if (rx_data == CMD_HALT) cmd_ok = 1'b1;
`endif
  end

  // Next reply byte is loaded on S_RESP entry or straight off the previous stop bit.
  assign tx_load = (state_q == S_RESP) && (rsp_left_q != 3'd0) &&
                   (!tx_act_q || ((tx_cnt_q == CLK_DIV) && (tx_bit_q == 4'd9)));

  assign tx_pin = tx_sh_q[0];
  assign req_o  = req_q;
  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      idx_q      <= '0;
      tout_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      rsp_q      <= '0;
      rsp_left_q <= '0;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_act_q   <= 1'b0;
`ifdef UART_DBG_HALT_EN
      halt_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_q  <= '0;
          tout_q <= '0;
          if (rx_valid) begin
            cmd_q  <= rx_data;
            busy_q <= 1'b1;
            if (cmd_ok) begin
              state_q <= S_ADDR;
            end else begin
              rsp_q      <= {24'h0, RSP_ERR};
              rsp_left_q <= 3'd1;
              state_q    <= S_RESP;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_ferr) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            tout_q <= '0;
`ifdef UART_DBG_HALT_EN
            if (cmd_q == CMD_HALT) begin
              halt_q     <= rx_data[0];
              rsp_q      <= {24'h0, RSP_OK};
              rsp_left_q <= 3'd1;
              state_q    <= S_RESP;
            end else
`endif
            begin
              // Fields arrive LSB byte first, so shift new bytes in from the top.
              if (state_q == S_ADDR) addr_q <= {rx_data, addr_q[31:8]};
              else                   data_q <= {rx_data, data_q[31:8]};
              idx_q <= idx_q + 3'd1;
              if (idx_q == 3'd3) begin
                idx_q <= '0;
                if ((state_q == S_ADDR) && (cmd_q == CMD_WR)) begin
                  state_q <= S_DATA;
                end else begin
                  state_q <= S_BUS;
                  req_q   <= 1'b1;
                  we_q    <= (cmd_q == CMD_WR);
                end
              end
            end
          end else if (rx_start) begin
            tout_q <= '0;
          end else if (tout_q >= (TIMEOUT_CYC - 32'd1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tout_q != '1) begin
            tout_q <= tout_q + 32'd1;
          end
        end
        S_BUS: begin
          if (ack_i) begin
            req_q   <= 1'b0;
            state_q <= S_RESP;
            if (we_q) begin
              rsp_q      <= {24'h0, RSP_OK};
              rsp_left_q <= 3'd1;
            end else begin
              rsp_q      <= data_i;
              rsp_left_q <= 3'd4;
            end
          end
        end
        S_RESP: begin
          if (tx_load) begin
            tx_sh_q    <= {1'b1, rsp_q[7:0], 1'b0};
            rsp_q      <= {8'h00, rsp_q[31:8]};
            rsp_left_q <= rsp_left_q - 3'd1;
            tx_act_q   <= 1'b1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
          end else if (tx_act_q) begin
            if (tx_cnt_q != CLK_DIV) begin
              tx_cnt_q <= tx_cnt_q + 16'd1;
            end else begin
              tx_cnt_q <= '0;
              if (tx_bit_q == 4'd9) begin
                tx_act_q <= 1'b0;
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
              end else begin
                tx_bit_q <= tx_bit_q + 4'd1;
                tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_dbg_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_dbg_bridge - table-driven bench with tx-byte and bus-transaction scoreboards. Rev 1.0
// ============================================================================
module tb_uart_dbg_bridge;

  localparam int DIV  = 7;
  localparam int BIT  = DIV + 1;
  localparam int TOUT = 400;

  logic        clk    = 1'b0;
  logic        rstn   = 1'b0;
  logic        rx_pin = 1'b1;
  logic        tx_pin;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i = '0;
  logic        ack_i  = 1'b0;
  logic        busy_o;
`ifdef UART_DBG_HALT_EN
  logic        halt_o;
`endif

  always #5 clk = ~clk;

  uart_dbg_bridge #(.CLK_DIV(16'(DIV)), .TIMEOUT_CYC(32'(TOUT))) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rx_pin (rx_pin),
    .tx_pin (tx_pin),
    .req_o  (req_o),
    .we_o   (we_o),
    .addr_o (addr_o),
    .data_o (data_o),
    .data_i (data_i),
    .ack_i  (ack_i),
`ifdef UART_DBG_HALT_EN
    .halt_o (halt_o),
`endif
    .busy_o (busy_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic [71:0] frame;
    int          nb;
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] rsp;
    int          nr;
  } vec_t;

  int         checks  = 0;
  int         errors  = 0;
  logic [8:0] tx_exp[$];
  bus_t       bus_exp[$];
  int         bus_lat = 0;
  bit         mon_en  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [71:0] f, input int nb, input logic bus, input logic we,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int lat, input logic [31:0] rsp, input int nr);
    vec_t v;
    v.frame = f;  v.nb = nb;   v.bus = bus; v.we = we;
    v.addr  = a;  v.wdata = wd; v.rdata = rd;
    v.lat   = lat; v.rsp = rsp; v.nr = nr;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_pin = stop;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    bus_t b;
    for (int i = 0; i < v.nr; i++) tx_exp.push_back({1'b1, v.rsp[8*i +: 8]});
    if (v.bus) begin
      b.we = v.we; b.addr = v.addr; b.wdata = v.wdata; b.rdata = v.rdata;
      bus_exp.push_back(b);
    end
    bus_lat = v.lat;
    for (int i = 0; i < v.nb; i++) send_byte(v.frame[8*i +: 8], 1'b1);
    wait_idle("busy_release");
    chk("tx_pending", 32'(tx_exp.size()), 32'd0);
    chk("bus_pending", 32'(bus_exp.size()), 32'd0);
  endtask

  // Serial monitor: decode each reply byte mid-bit and pop the expected byte.
  initial begin
    logic [8:0] b;
    bit         en;
    forever begin
      @(negedge tx_pin);
      en = mon_en;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = tx_pin;
      end
      if (en) begin
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected none", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
        end
      end
    end
  end

  // Bus responder: check the request against the scoreboard, ack after bus_lat cycles.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (req_o === 1'b1) begin
        if (bus_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got addr %h we %b expected no request", addr_o, we_o);
          e = '0;
        end else begin
          e = bus_exp.pop_front();
          chk("bus_we", 32'(we_o), 32'(e.we));
          chk("bus_addr", addr_o, e.addr);
          if (e.we) chk("bus_wdata", data_o, e.wdata);
        end
        for (int i = 0; i < bus_lat; i++) begin
          @(negedge clk);
          chk("req_held", 32'(req_o), 32'd1);
          chk("addr_stable", addr_o, e.addr);
        end
        data_i = e.rdata;
        ack_i  = 1'b1;
        @(negedge clk);
        ack_i  = 1'b0;
        data_i = '0;
        chk("req_drop", 32'(req_o), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_pin), 32'd1);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
`ifdef UART_DBG_HALT_EN
    chk("rst_halt", 32'(halt_o), 32'd0);
`endif
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    tbl[0] = mk({32'hDEADBEEF, 32'h20000010, 8'h57}, 9, 1'b1, 1'b1, 32'h20000010, 32'hDEADBEEF, 32'h0, 1, 32'h4B, 1);
    tbl[1] = mk({32'h0, 32'h10000004, 8'h52}, 5, 1'b1, 1'b0, 32'h10000004, 32'h0, 32'h12345678, 3, 32'h12345678, 4);
    tbl[2] = mk(72'hA5, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h45, 1);
    tbl[3] = mk({32'h0, 32'hFFFFFFFC, 8'h52}, 5, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hA5A55A5A, 0, 32'hA5A55A5A, 4);
    tbl[4] = mk({32'h00000001, 32'h00000000, 8'h57}, 9, 1'b1, 1'b1, 32'h0, 32'h1, 32'h0, 0, 32'h4B, 1);
`ifdef UART_DBG_HALT_EN
    tbl[5] = mk({8'h01, 8'h48}, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h4B, 1);
`else
    tbl[5] = mk(72'h48, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h45, 1);
`endif
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

`ifdef UART_DBG_HALT_EN
    chk("halt_set", 32'(halt_o), 32'd1);
    run_vec(mk({8'h00, 8'h48}, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h4B, 1));
    chk("halt_clr", 32'(halt_o), 32'd0);
`endif

    // Framing error on a lone byte, then inside a frame.
    send_byte(8'hFF, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_idle_busy", 32'(busy_o), 32'd0);
    send_byte(8'h57, 1'b1);
    chk("ferr_frame_busy", 32'(busy_o), 32'd1);
    send_byte(8'h10, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_abort_busy", 32'(busy_o), 32'd0);

    // Short start-bit glitch is ignored.
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_busy", 32'(busy_o), 32'd0);

    // Partial write discarded by timeout; the following read is the only transaction.
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("to_pending_busy", 32'(busy_o), 32'd1);
    repeat (TOUT + 10) @(negedge clk);
    chk("to_busy", 32'(busy_o), 32'd0);
    run_vec(mk({32'h0, 32'h0, 8'h52}, 5, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 2, 32'hCAFEF00D, 4));

    // Asynchronous reset in the middle of the second reply byte.
    mon_en = 1'b0;
    begin
      bus_t b;
      b.we = 1'b0; b.addr = 32'h40; b.wdata = '0; b.rdata = 32'h000000FF;
      bus_exp.push_back(b);
    end
    bus_lat = 0;
    send_byte(8'h52, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    n = 0;
    while (tx_pin !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (13 * BIT) @(negedge clk);
    chk("rst_mid_tx_low", 32'(tx_pin), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx_pin), 32'd1);
    chk("rst_async_req", 32'(req_o), 32'd0);
    chk("rst_async_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_bus_done", 32'(bus_exp.size()), 32'd0);
    run_vec(mk({32'h01234567, 32'h30000000, 8'h57}, 9, 1'b1, 1'b1, 32'h30000000, 32'h01234567, 32'h0, 2, 32'h4B, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
